// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: bubble instruction, reset PC default, IF-stage states
// and the IF/ID pipeline register layout.
package if_stage_pkg;

    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2,
        S_TRAP = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        misalign;
    } if_id_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with load/hold/flush; reset leaves a bubble at pc 0.
// Priority: reset > load > flush > hold. Flush keeps the pc field.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    input  logic        d_valid,
    input  logic        d_misalign,
    output logic [31:0] q_pc,
    output logic [31:0] q_instr,
    output logic        q_valid,
    output logic        q_misalign
);

    if_id_t slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0, misalign: 1'b0};
        end else if (load) begin
            slot <= '{pc: d_pc, instr: d_instr, valid: d_valid, misalign: d_misalign};
        end else if (flush) begin
            slot.instr    <= NOP_INSTR;
            slot.valid    <= 1'b0;
            slot.misalign <= 1'b0;
        end
    end

    assign q_pc       = slot.pc;
    assign q_instr    = slot.instr;
    assign q_valid    = slot.valid;
    assign q_misalign = slot.misalign;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// stall skid, redirect-while-pending drop and misaligned-target trap.
//
// state  | meaning
// S_REQ  | request at pc_if outstanding, waiting for valid
// S_HOLD | word captured in skid while stalled, no request
// S_DROP | redirect seen with request pending; old response will be discarded
// S_TRAP | misaligned redirect target reported, fetch halted
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
    parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_next,
    input  logic        i_br_taken,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_if,
    output logic [31:0] o_pc_plus4_if,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_instr_id,
    output logic        o_valid_id,
    output logic        o_misalign_id
);

    if_state_e   state, state_nxt;
    logic [31:0] pc_if, pc_nxt;
    logic [31:0] skid, skid_nxt;
    logic [31:0] redir, redir_nxt;

    logic        take_target;
    logic [31:0] target;
    logic        ld, fl;
    logic [31:0] d_pc, d_instr;
    logic        d_misalign;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_REQ;
            pc_if <= RESET_PC;
            skid  <= 32'h0;
            redir <= 32'h0;
        end else begin
            state <= state_nxt;
            pc_if <= pc_nxt;
            skid  <= skid_nxt;
            redir <= redir_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_if;
        skid_nxt    = skid;
        redir_nxt   = redir;
        take_target = 1'b0;
        target      = i_pc_next;
        ld          = 1'b0;
        fl          = 1'b0;
        d_pc        = pc_if;
        d_instr     = i_imem_rdata;
        d_misalign  = 1'b0;

        if (i_br_taken) begin
            if ((state == S_REQ || state == S_DROP) && !i_imem_valid) begin
                state_nxt = S_DROP;
                redir_nxt = i_pc_next;
                fl        = 1'b1;
            end else begin
                take_target = 1'b1;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (i_imem_valid) begin
                        if (i_stall) begin
                            skid_nxt  = i_imem_rdata;
                            state_nxt = S_HOLD;
                        end else begin
                            ld     = 1'b1;
                            pc_nxt = i_pc_next;
                        end
                    end else if (!i_stall) begin
                        fl = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        ld        = 1'b1;
                        d_instr   = skid;
                        pc_nxt    = i_pc_next;
                        state_nxt = S_REQ;
                    end
                end
                S_DROP: begin
                    // The discarded response retires the old request even under stall;
                    // IF/ID already holds a bubble from the redirect flush.
                    if (i_imem_valid) begin
                        take_target = 1'b1;
                        target      = redir;
                    end else if (!i_stall) begin
                        fl = 1'b1;
                    end
                end
                S_TRAP: begin
                    if (!i_stall) begin
                        fl = 1'b1;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end

        if (take_target) begin
            pc_nxt = target;
            if (is_misaligned(target)) begin
                state_nxt  = S_TRAP;
                ld         = 1'b1;
                d_pc       = target;
                d_instr    = NOP_INSTR;
                d_misalign = 1'b1;
            end else begin
                state_nxt = S_REQ;
                fl        = 1'b1;
            end
        end
    end

    assign o_imem_req    = (state == S_REQ || state == S_DROP) && !i_reset;
    assign o_imem_addr   = pc_if;
    assign o_pc_if       = pc_if;
    assign o_pc_plus4_if = pc_if + 32'd4;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (i_clk),
        .reset      (i_reset),
        .load       (ld),
        .flush      (fl),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_valid    (1'b1),
        .d_misalign (d_misalign),
        .q_pc       (o_pc_id),
        .q_instr    (o_instr_id),
        .q_valid    (o_valid_id),
        .q_misalign (o_misalign_id)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns 0xA000_0000 ^ addr, next-PC mux
// modelled as target-on-redirect else pc+4.
module tb_if_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc_next;
    logic        i_br_taken;
    logic        i_stall;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_pc_if;
    logic [31:0] o_pc_plus4_if;
    logic [31:0] o_pc_id;
    logic [31:0] o_instr_id;
    logic        o_valid_id;
    logic        o_misalign_id;

    logic [31:0] br_target;
    int          checks   = 0;
    int          failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA000_0000;

    always #5 i_clk = ~i_clk;

    assign i_pc_next    = i_br_taken ? br_target : o_pc_plus4_if;
    assign i_imem_rdata = TAG ^ o_imem_addr;

    if_stage dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_pc_next     (i_pc_next),
        .i_br_taken    (i_br_taken),
        .i_stall       (i_stall),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_valid  (i_imem_valid),
        .i_imem_rdata  (i_imem_rdata),
        .o_pc_if       (o_pc_if),
        .o_pc_plus4_if (o_pc_plus4_if),
        .o_pc_id       (o_pc_id),
        .o_instr_id    (o_instr_id),
        .o_valid_id    (o_valid_id),
        .o_misalign_id (o_misalign_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_br_taken   = 1'b0;
        i_stall      = 1'b0;
        i_imem_valid = 1'b0;
        br_target    = 32'h0;
        #1;
        tick();
        tick();
        chk("rst_req", o_imem_req, 0);
        chk("rst_pc_if", o_pc_if, 32'h0);
        chk("rst_pc_id", o_pc_id, 32'h0);
        chk("rst_instr_id", o_instr_id, NOP);
        chk("rst_valid_id", o_valid_id, 0);
        chk("rst_mis_id", o_misalign_id, 0);

        // zero-wait streaming
        i_reset      = 1'b0;
        i_imem_valid = 1'b1;
        #1;
        chk("zw_req", o_imem_req, 1);
        chk("zw_addr", o_imem_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("zw_valid_id", o_valid_id, 1);
            chk("zw_pc_id", o_pc_id, 32'(k * 4));
            chk("zw_instr_id", o_instr_id, TAG ^ 32'(k * 4));
        end
        chk("zw_pc_if", o_pc_if, 32'h10);

        // three-cycle latency at 0x10
        i_imem_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lat_req", o_imem_req, 1);
            chk("lat_addr", o_imem_addr, 32'h10);
            tick();
            chk("lat_bubble_valid", o_valid_id, 0);
            chk("lat_bubble_instr", o_instr_id, NOP);
        end
        i_imem_valid = 1'b1;
        #1;
        chk("lat_addr3", o_imem_addr, 32'h10);
        tick();
        chk("lat_pc_id", o_pc_id, 32'h10);
        chk("lat_valid_id", o_valid_id, 1);
        chk("lat_pc_if", o_pc_if, 32'h14);

        // stall two cycles with a word arriving
        i_stall = 1'b1;
        tick();
        chk("stl_pc_if", o_pc_if, 32'h14);
        chk("stl_pc_id", o_pc_id, 32'h10);
        i_imem_valid = 1'b0;
        #1;
        chk("stl_hold_req", o_imem_req, 0);
        tick();
        chk("stl_pc_id2", o_pc_id, 32'h10);
        chk("stl_valid_id2", o_valid_id, 1);
        i_stall = 1'b0;
        #1;
        chk("stl_rel_req", o_imem_req, 0);
        tick();
        chk("stl_skid_pc", o_pc_id, 32'h14);
        chk("stl_skid_instr", o_instr_id, TAG ^ 32'h14);
        chk("stl_pc_if2", o_pc_if, 32'h18);
        i_imem_valid = 1'b1;
        tick();
        chk("stl_next_pc", o_pc_id, 32'h18);
        chk("stl_next_instr", o_instr_id, TAG ^ 32'h18);
        tick();
        chk("stl_pc_if3", o_pc_if, 32'h20);

        // redirect to 0x100 while request at 0x20 is pending
        i_imem_valid = 1'b0;
        i_br_taken   = 1'b1;
        br_target    = 32'h100;
        #1;
        chk("drp_addr0", o_imem_addr, 32'h20);
        tick();
        chk("drp_flush_valid", o_valid_id, 0);
        chk("drp_flush_instr", o_instr_id, NOP);
        i_br_taken = 1'b0;
        #1;
        chk("drp_req", o_imem_req, 1);
        chk("drp_addr1", o_imem_addr, 32'h20);
        tick();
        i_imem_valid = 1'b1;
        #1;
        chk("drp_addr2", o_imem_addr, 32'h20);
        tick();
        chk("drp_pc_if", o_pc_if, 32'h100);
        chk("drp_dropped", o_valid_id, 0);
        chk("drp_new_addr", o_imem_addr, 32'h100);
        tick();
        chk("drp_tgt_pc_id", o_pc_id, 32'h100);
        chk("drp_tgt_instr", o_instr_id, TAG ^ 32'h100);
        chk("drp_tgt_valid", o_valid_id, 1);

        // reset while in S_DROP, stale valid during reset
        i_imem_valid = 1'b0;
        i_br_taken   = 1'b1;
        br_target    = 32'h200;
        tick();
        i_br_taken   = 1'b0;
        i_reset      = 1'b1;
        i_imem_valid = 1'b1;
        #1;
        chk("rdrp_req_in_rst", o_imem_req, 0);
        tick();
        chk("rdrp_pc_if", o_pc_if, 32'h0);
        chk("rdrp_valid_id", o_valid_id, 0);
        i_reset      = 1'b0;
        i_imem_valid = 1'b0;
        #1;
        chk("rdrp_req", o_imem_req, 1);
        chk("rdrp_addr", o_imem_addr, 32'h0);
        tick();
        chk("rdrp_bubble", o_valid_id, 0);
        i_imem_valid = 1'b1;
        tick();
        chk("rdrp_pc_id", o_pc_id, 32'h0);
        chk("rdrp_valid_id2", o_valid_id, 1);

        // misaligned redirect to 0x102
        i_br_taken = 1'b1;
        br_target  = 32'h102;
        tick();
        chk("trp_pc_id", o_pc_id, 32'h102);
        chk("trp_instr", o_instr_id, NOP);
        chk("trp_valid", o_valid_id, 1);
        chk("trp_mis", o_misalign_id, 1);
        chk("trp_pc_if", o_pc_if, 32'h102);
        i_br_taken   = 1'b0;
        i_imem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("trp_no_req", o_imem_req, 0);
            tick();
            chk("trp_after_valid", o_valid_id, 0);
            chk("trp_after_mis", o_misalign_id, 0);
        end

        // redirect out of trap to top of address space; pc+4 wraps
        i_br_taken = 1'b1;
        br_target  = 32'hFFFF_FFFC;
        tick();
        i_br_taken = 1'b0;
        #1;
        chk("wrap_pc_if", o_pc_if, 32'hFFFF_FFFC);
        chk("wrap_plus4", o_pc_plus4_if, 32'h0);
        chk("wrap_req", o_imem_req, 1);
        chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
